// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the ECC-protected block RAM banks of the patch-sync
// reorder window.
//   - BRAM_ADDR_W / BRAM_DATA_W : default address and user-data widths
//   - parity_w()                : SECDED check-bit count for a data width
//   - is_pow2() / check_pos()   : Hamming check-bit positions (1, 2, 4, ...)
//   - data_pos()                : codeword position of user data bit n
// Codeword layout: bit 0 is the overall-parity bit, bits at power-of-two
// positions are Hamming check bits, all other positions carry data in
// ascending order.
// -----------------------------------------------------------------------------
package bram_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 21;

  // True for the Hamming check-bit positions 1, 2, 4, 8, ...
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Position of Hamming check bit k.
  function automatic int check_pos(input int k);
    return 1 << k;
  endfunction

  // Hamming bits r satisfy 2**r >= data_w + r + 1; one more for overall parity.
  function automatic int parity_w(input int data_w);
    int r;
    r = 0;
    while ((1 << r) < data_w + r + 1) r++;
    return r + 1;
  endfunction

  // n-th non-power-of-two position starting at 3 (position 0 is overall parity).
  function automatic int data_pos(input int n);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 256; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == n && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// -----------------------------------------------------------------------------
// secded_codec
// Purely combinational extended-Hamming (SECDED) encoder and decoder.
// Ports:
//   i_enc_data  : user data to encode
//   o_enc_code  : encoded codeword
//   i_dec_code  : codeword to check
//   o_dec_data  : data, corrected on a single-bit error, raw on a double error
//   o_dec_sbit  : a single-bit error was corrected
//   o_dec_dbit  : an uncorrectable double-bit error was detected
// -----------------------------------------------------------------------------
module secded_codec
  import bram_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic [DATA_W-1:0]                  i_enc_data,
  output logic [DATA_W+parity_w(DATA_W)-1:0] o_enc_code,
  input  logic [DATA_W+parity_w(DATA_W)-1:0] i_dec_code,
  output logic [DATA_W-1:0]                  o_dec_data,
  output logic                               o_dec_sbit,
  output logic                               o_dec_dbit
);

  localparam int P  = parity_w(DATA_W);
  localparam int HP = P - 1;           // Hamming check bits, excluding overall parity
  localparam int CW = DATA_W + P;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [CW-1:0] code;
    logic          par;
    code = '0;
    par  = 1'b0;
    for (int i = 0; i < DATA_W; i++) code[data_pos(i)] = i_enc_data[i];
    for (int k = 0; k < HP; k++) begin
      par = 1'b0;
      for (int j = 3; j < CW; j++) begin
        if (!is_pow2(j) && ((j >> k) & 1) == 1) par ^= code[j];
      end
      code[check_pos(k)] = par;
    end
    code[0]    = ^code[CW-1:1];
    o_enc_code = code;
  end

  // Syndrome is the XOR of the positions of all set bits; Q is the parity of
  // the whole word including the overall-parity bit.
  always_comb begin
    logic [HP-1:0] syn;
    logic          q;
    logic [CW-1:0] fixed;
    syn   = '0;
    q     = ^i_dec_code;
    fixed = i_dec_code;
    for (int j = 1; j < CW; j++) begin
      if (i_dec_code[j]) syn ^= HP'(j);
    end
    // Odd error count: flip the addressed bit (syndrome 0 is the parity bit).
    for (int j = 0; j < CW; j++) begin
      if (q && syn == HP'(j)) fixed[j] = ~i_dec_code[j];
    end
    for (int i = 0; i < DATA_W; i++) o_dec_data[i] = fixed[data_pos(i)];
    o_dec_sbit = q;
    o_dec_dbit = !q && (syn != '0);
  end

endmodule

// File: rtl/bram21_sdp.sv
// -----------------------------------------------------------------------------
// bram21_sdp
// Simple dual-port 2**ADDR_W x DATA_W block RAM with SECDED ECC; one bank of
// the patch-sync reorder window. Words are {have_bit, wtsum[19:0]}.
// Ports:
//   CLK       : single clock for both ports
//   RESET     : synchronous, active-low; clears the read outputs, blocks writes
//   wea       : port A write enable
//   addra     : port A write address
//   dina      : port A write data (encoded before storing)
//   addrb     : port B read address, sampled every cycle
//   doutb     : registered, ECC-corrected read data (1-cycle latency)
//   sbiterr   : single-bit error corrected in doutb
//   dbiterr   : uncorrectable double-bit error in doutb
//   rdaddrecc : address of the flagged word, 0 when no flag is set
// Same-address write/read in one cycle is read-first. No scrubbing.
// -----------------------------------------------------------------------------
module bram21_sdp
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DELAY  = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              sbiterr,
  output logic              dbiterr,
  output logic [ADDR_W-1:0] rdaddrecc
);

  localparam int CW    = DATA_W + parity_w(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  // DELAY only shaped simulation timing in the original model; this RTL is
  // zero-delay, so the parameter is kept for instantiation compatibility.
  logic w_unused_delay;
  assign w_unused_delay = (DELAY != 0);

  logic [CW-1:0]     mem [0:DEPTH-1];
  logic [CW-1:0]     w_wr_code;
  logic [CW-1:0]     w_rd_code;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_sbit;
  logic              w_dbit;

  // Asynchronous array read feeding the decoder; the result is registered
  // below, so the write at the same edge is not seen (read-first).
  assign w_rd_code = mem[addrb];

  secded_codec #(
    .DATA_W (DATA_W)
  ) u_codec (
    .i_enc_data (dina),
    .o_enc_code (w_wr_code),
    .i_dec_code (w_rd_code),
    .o_dec_data (w_rd_data),
    .o_dec_sbit (w_sbit),
    .o_dec_dbit (w_dbit)
  );

  // NOTE: the array has no reset branch; clearing it would stop synthesis
  // from mapping it to block RAM, and contents must survive reset anyway.
  always_ff @(posedge CLK) begin
    if (RESET && wea) mem[addra] <= w_wr_code;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      doutb     <= '0;
      sbiterr   <= 1'b0;
      dbiterr   <= 1'b0;
      rdaddrecc <= '0;
    end else begin
      doutb     <= w_rd_data;
      sbiterr   <= w_sbit;
      dbiterr   <= w_dbit;
      rdaddrecc <= (w_sbit || w_dbit) ? addrb : '0;
    end
  end

endmodule

// File: tb/tb_bram21_sdp.sv
// -----------------------------------------------------------------------------
// tb_bram21_sdp
// Self-checking bench for bram21_sdp. A plain array holds the expected user
// data per address; error injection flips stored codeword bits directly.
// -----------------------------------------------------------------------------
module tb_bram21_sdp;

  localparam int AW = 10;
  localparam int DW = 21;
  localparam int CW = 27;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          sbiterr;
  logic          dbiterr;
  logic [AW-1:0] rdaddrecc;

  logic [DW-1:0] model [0:1023];
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 CLK = ~CLK;

  bram21_sdp dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .addrb     (addrb),
    .doutb     (doutb),
    .sbiterr   (sbiterr),
    .dbiterr   (dbiterr),
    .rdaddrecc (rdaddrecc)
  );

  // Inputs change after the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // User-data bit carried at a codeword position (positions 1,2,4,.. are
  // check bits, 0 is overall parity, data fills the rest from 3 upward).
  function automatic int data_bit_at(input int pos);
    int n;
    n = 0;
    for (int p = 3; p < pos; p++) if ((p & (p - 1)) != 0) n++;
    return n;
  endfunction

  task automatic flip_bits(input int a, input logic [CW-1:0] mask);
    dut.mem[a] = dut.mem[a] ^ mask;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    wea   = 1'b1;
    addra = AW'(a);
    dina  = d;
    tick();
    wea   = 1'b0;
    model[a] = d;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    wea   = 1'b0;
    addrb = 10'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if ({doutb, sbiterr, dbiterr, rdaddrecc} !== '0)
        $display("FAIL reset cyc%0d: dout=%h s=%b d=%b ra=%0d, required all 0",
                 c, doutb, sbiterr, dbiterr, rdaddrecc);
      else n_pass++;
    end
    RESET = 1'b1;
  endtask

  task automatic test_sweep();
    int errs;
    for (int a = 0; a < 1024; a++)
      write_word(a, {11'b0, AW'(a) ^ 10'h2AA});
    errs = 0;
    for (int a = 0; a < 1024; a++) begin
      addrb = AW'(a);
      tick();
      if (doutb !== model[a] || sbiterr !== 1'b0 || dbiterr !== 1'b0 || rdaddrecc !== '0) begin
        if (errs < 5)
          $display("FAIL sweep a=%0d: dout=%h s=%b d=%b ra=%0d, required %h 0 0 0",
                   a, doutb, sbiterr, dbiterr, rdaddrecc, model[a]);
        errs++;
      end
    end
    n_total++;
    if (errs != 0) $display("FAIL sweep: %0d bad words, required 0", errs);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    write_word(5, 21'h1FFFFF);
    addrb = 10'd5;
    tick();
    n_total++;
    if (doutb !== 21'h1FFFFF) $display("FAIL b2b_5: dout=%h, required 1fffff", doutb);
    else n_pass++;
    write_word(1023, 21'h15A5A5);
    addrb = 10'd1023;
    tick();
    n_total++;
    if (doutb !== 21'h15A5A5) $display("FAIL b2b_1023: dout=%h, required 15a5a5", doutb);
    else n_pass++;
    addrb = 10'd0;
    tick();
    n_total++;
    if (doutb !== model[0]) $display("FAIL wrap_0: dout=%h, required %h", doutb, model[0]);
    else n_pass++;
  endtask

  task automatic test_collision();
    write_word(7, 21'h000123);
    wea   = 1'b1;
    addra = 10'd7;
    dina  = 21'h0ABCDE;
    addrb = 10'd7;
    tick();
    wea = 1'b0;
    model[7] = 21'h0ABCDE;
    n_total++;
    if (doutb !== 21'h000123) $display("FAIL collision_old: dout=%h, required 000123", doutb);
    else n_pass++;
    tick();
    n_total++;
    if (doutb !== 21'h0ABCDE) $display("FAIL collision_new: dout=%h, required 0abcde", doutb);
    else n_pass++;
  endtask

  task automatic test_single_bit();
    // data bit 3 lives at codeword position 7
    flip_bits(12, 27'(1) << 7);
    addrb = 10'd12;
    tick();
    n_total++;
    if (doutb !== model[12] || sbiterr !== 1'b1 || dbiterr !== 1'b0 || rdaddrecc !== 10'd12)
      $display("FAIL sbit_data: dout=%h s=%b d=%b ra=%0d, required %h 1 0 12",
               doutb, sbiterr, dbiterr, rdaddrecc, model[12]);
    else n_pass++;
    // No scrubbing: the stored word stays corrupted.
    tick();
    n_total++;
    if (doutb !== model[12] || sbiterr !== 1'b1)
      $display("FAIL sbit_noscrub: dout=%h s=%b, required %h 1", doutb, sbiterr, model[12]);
    else n_pass++;
    // Hamming check bit at position 4
    flip_bits(13, 27'(1) << 4);
    addrb = 10'd13;
    tick();
    n_total++;
    if (doutb !== model[13] || sbiterr !== 1'b1 || dbiterr !== 1'b0 || rdaddrecc !== 10'd13)
      $display("FAIL sbit_check: dout=%h s=%b d=%b ra=%0d, required %h 1 0 13",
               doutb, sbiterr, dbiterr, rdaddrecc, model[13]);
    else n_pass++;
    // Overall-parity bit
    flip_bits(14, 27'(1));
    addrb = 10'd14;
    tick();
    n_total++;
    if (doutb !== model[14] || sbiterr !== 1'b1 || rdaddrecc !== 10'd14)
      $display("FAIL sbit_overall: dout=%h s=%b ra=%0d, required %h 1 14",
               doutb, sbiterr, rdaddrecc, model[14]);
    else n_pass++;
    write_word(12, model[12]);
    write_word(13, model[13]);
    write_word(14, model[14]);
  endtask

  task automatic test_double_bit();
    logic [DW-1:0] raw;
    flip_bits(40, (27'(1) << 7) | (27'(1) << 10));
    raw = model[40] ^ (DW'(1) << data_bit_at(7)) ^ (DW'(1) << data_bit_at(10));
    addrb = 10'd40;
    tick();
    n_total++;
    if (dbiterr !== 1'b1 || sbiterr !== 1'b0 || rdaddrecc !== 10'd40 || doutb !== raw)
      $display("FAIL dbit: dout=%h s=%b d=%b ra=%0d, required %h 0 1 40",
               doutb, sbiterr, dbiterr, rdaddrecc, raw);
    else n_pass++;
    addrb = 10'd41;
    tick();
    n_total++;
    if (doutb !== model[41] || sbiterr !== 1'b0 || dbiterr !== 1'b0 || rdaddrecc !== '0)
      $display("FAIL dbit_clean_after: dout=%h s=%b d=%b ra=%0d, required %h 0 0 0",
               doutb, sbiterr, dbiterr, rdaddrecc, model[41]);
    else n_pass++;
    write_word(40, model[40]);
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    int            errs;
    int            ra;
    int            wa;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      wa = int'($urandom_range(1023));
      ra = ($urandom_range(3) == 0) ? wa : int'($urandom_range(1023));
      wea   = $urandom_range(1) == 1;
      addra = AW'(wa);
      dina  = DW'($urandom);
      addrb = AW'(ra);
      exp_d = model[ra];              // read-first
      if (wea) model[wa] = dina;
      tick();
      if (doutb !== exp_d || sbiterr !== 1'b0 || dbiterr !== 1'b0 || rdaddrecc !== '0) begin
        if (errs < 5)
          $display("FAIL random c=%0d a=%0d: dout=%h s=%b d=%b, required %h 0 0",
                   c, ra, doutb, sbiterr, dbiterr, exp_d);
        errs++;
      end
    end
    wea = 1'b0;
    n_total++;
    if (errs != 0) $display("FAIL random: %0d bad reads, required 0", errs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old61;
    old61 = model[61];
    addrb = 10'd60;
    tick();
    n_total++;
    if (doutb !== model[60]) $display("FAIL rstmid_pre: dout=%h, required %h", doutb, model[60]);
    else n_pass++;
    RESET = 1'b0;
    wea   = 1'b1;
    addra = 10'd61;
    dina  = ~old61;
    addrb = 10'd61;
    tick();
    n_total++;
    if ({doutb, sbiterr, dbiterr, rdaddrecc} !== '0)
      $display("FAIL rstmid_zero: dout=%h s=%b d=%b ra=%0d, required all 0",
               doutb, sbiterr, dbiterr, rdaddrecc);
    else n_pass++;
    RESET = 1'b1;
    wea   = 1'b0;
    tick();
    n_total++;
    if (doutb !== old61) $display("FAIL rstmid_blocked: dout=%h, required %h", doutb, old61);
    else n_pass++;
    addrb = 10'd62;
    tick();
    n_total++;
    if (doutb !== model[62]) $display("FAIL rstmid_kept: dout=%h, required %h", doutb, model[62]);
    else n_pass++;
  endtask

  initial begin
    RESET = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    addrb = '0;
    @(negedge CLK);
    test_reset();
    test_sweep();
    test_back_to_back();
    test_collision();
    test_single_bit();
    test_double_bit();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
